// File: rtl/fft_bitrev_feeder_pkg.sv
// Shared definitions for the bit-reversing FFT input feeder: sample width
// macro, reader state encodings and the index bit-reversal helper.
`define FFT_SAMPLE_W(xw) ((xw) * 2)

package fft_bitrev_feeder_pkg;

  localparam int MAX_NLOG2 = 16;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_READ = 1'b1;

  // Reverses the low nlog2 bits of idx; bits above nlog2 come back as zero.
  function automatic logic [MAX_NLOG2-1:0] bitrev(input logic [MAX_NLOG2-1:0] idx,
                                                  input int nlog2);
    logic [MAX_NLOG2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_NLOG2; i++) begin
      if (i < nlog2) r[i] = idx[nlog2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample buffer: one write port, one synchronous read port,
// addressed as {bank, index}.
module fft_pingpong_ram #(
  parameter int NLOG2 = 3,
  parameter int DW    = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_i,
  input  logic [NLOG2:0] waddr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic           re_i,
  input  logic [NLOG2:0] raddr_i,
  output logic [DW-1:0]  rdata_o
);

  logic [DW-1:0] mem_q [2**(NLOG2+1)];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The read register doubles as the block's output register, so only it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/fft_bitrev_feeder.sv
// Buffers natural-order frames into a ping-pong RAM and replays each complete
// frame in bit-reversed order as a contiguous burst for the dit core.
module fft_bitrev_feeder
  import fft_bitrev_feeder_pkg::*;
#(
  parameter int N      = 8,
  parameter int NLOG2  = 3,
  parameter int X_WDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [`FFT_SAMPLE_W(X_WDTH)-1:0]  in_data,
  input  logic                              in_nd,
  input  logic                              in_first,
  output logic [`FFT_SAMPLE_W(X_WDTH)-1:0]  out_data,
  output logic                              out_nd,
  output logic                              error
);

  localparam logic [NLOG2-1:0] LAST_IDX = NLOG2'(N - 1);

  logic [NLOG2-1:0] wr_idx_q, wr_idx_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       full_q, full_d;
  logic [1:0]       set_full, clr_full;
  logic             frame_err;
  logic [NLOG2-1:0] wr_addr_idx;

  logic [0:0]       state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [NLOG2-1:0] rd_idx_q, rd_idx_d;
  logic             rd_en;
  logic             rd_bank_sel;
  logic [NLOG2-1:0] rd_idx_sel;
  logic [NLOG2-1:0] rd_addr_idx;

  logic             out_nd_q;
  logic             error_q;

  // A marker mid-frame restarts the same bank with the marked sample at index 0.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    set_full    = 2'b00;
    frame_err   = in_nd && in_first && (wr_idx_q != '0);
    wr_addr_idx = frame_err ? '0 : wr_idx_q;
    if (in_nd) begin
      if (frame_err) begin
        wr_idx_d = NLOG2'(1);
      end else if (wr_idx_q == LAST_IDX) begin
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_idx_d            = '0;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
  end

  // IDLE issues index 0 in the same cycle it spots a full bank, which keeps
  // the output contiguous even when the next frame completes on the last read.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    clr_full    = 2'b00;
    rd_en       = 1'b0;
    rd_bank_sel = rd_bank_q;
    rd_idx_sel  = rd_idx_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q != 2'b00) begin
          rd_en       = 1'b1;
          rd_bank_sel = (&full_q) ? wr_bank_q : full_q[1];
          rd_idx_sel  = '0;
          rd_bank_d   = rd_bank_sel;
          rd_idx_d    = NLOG2'(1);
          state_d     = RD_READ;
        end
      end
      default: begin
        rd_en = 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_idx_d            = '0;
          if (full_q[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
    endcase
  end

  assign rd_addr_idx = NLOG2'(bitrev(MAX_NLOG2'(rd_idx_sel), NLOG2));
  assign full_d      = (full_q & ~clr_full) | set_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      out_nd_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      out_nd_q  <= rd_en;
      error_q   <= frame_err;
    end
  end

  fft_pingpong_ram #(
    .NLOG2(NLOG2),
    .DW   (`FFT_SAMPLE_W(X_WDTH))
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (in_nd),
    .waddr_i({wr_bank_q, wr_addr_idx}),
    .wdata_i(in_data),
    .re_i   (rd_en),
    .raddr_i({rd_bank_sel, rd_addr_idx}),
    .rdata_o(out_data)
  );

  assign out_nd = out_nd_q;
  assign error  = error_q;

endmodule

// File: tb/tb_fft_bitrev_feeder.sv
// Scoreboard bench for fft_bitrev_feeder: a frame-level reference model queues
// expected outputs and error pulses with their cycles; a monitor checks them.
module tb_fft_bitrev_feeder;

  localparam int N     = 8;
  localparam int NLOG2 = 3;
  localparam int XW    = 16;
  localparam int SW    = 2 * XW;

  typedef struct packed {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_data;
  logic          in_nd;
  logic          in_first;
  logic [SW-1:0] out_data;
  logic          out_nd;
  logic          error;

  int checks    = 0;
  int errors    = 0;
  int edgeCount = 0;
  int lastSched = 0;
  int invViol   = 0;
  int outSeen   = 0;

  exp_t          expQ[$];
  int            errQ[$];
  logic [SW-1:0] frameBuf[$];

  fft_bitrev_feeder #(.N(N), .NLOG2(NLOG2), .X_WDTH(XW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_nd   (in_nd),
    .in_first(in_first),
    .out_data(out_data),
    .out_nd  (out_nd),
    .error   (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edgeCount <= edgeCount + 1;

  function automatic int revIdx(input int k);
    int r = 0;
    for (int b = 0; b < NLOG2; b++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, edgeCount + 1);
    end
  endtask

  // Frame-level model: a frame is N accepted samples; a marker mid-frame restarts it.
  task automatic modelAccept(input logic [SW-1:0] data, input logic first, input int cyc);
    int start;
    if (first && frameBuf.size() != 0) begin
      errQ.push_back(cyc + 1);
      frameBuf.delete();
    end
    frameBuf.push_back(data);
    if (frameBuf.size() == N) begin
      start = (cyc + 2 > lastSched + 1) ? cyc + 2 : lastSched + 1;
      for (int j = 0; j < N; j++) expQ.push_back('{data: frameBuf[revIdx(j)], cyc: start + j});
      lastSched = start + N - 1;
      frameBuf.delete();
    end
  endtask

  task automatic applyStimulus(input logic [SW-1:0] data, input logic nd, input logic first);
    @(negedge clk);
    in_data  = data;
    in_nd    = nd;
    in_first = first;
    if (nd) modelAccept(data, first, edgeCount + 1);
  endtask

  task automatic checkOutput();
    exp_t e;
    int   now;
    int   ecyc;
    now = edgeCount + 1;
    if (out_nd) begin
      outSeen++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_out: got data %0h at cycle %0d, expected no output", out_data, now);
      end else begin
        e = expQ.pop_front();
        checkVal("out_data", out_data, e.data);
        checkVal("out_cycle", SW'(now), SW'(e.cyc));
      end
    end else if (expQ.size() != 0 && expQ[0].cyc <= now) begin
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_out: out_nd 0 at cycle %0d, expected data %0h", now, e.data);
    end
    if (error) begin
      if (errQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_error: error 1 at cycle %0d, expected 0", now);
      end else begin
        ecyc = errQ.pop_front();
        checkVal("error_cycle", SW'(now), SW'(ecyc));
      end
    end else if (errQ.size() != 0 && errQ[0] <= now) begin
      ecyc = errQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_error: error 0 at cycle %0d, expected pulse at %0d", now, ecyc);
    end
    if (dut.full_q[dut.wr_bank_q]) invViol++;
  endtask

  always @(negedge clk) if (!rst) checkOutput();

  task automatic waitDrain();
    int budget = 200;
    while ((expQ.size() != 0 || errQ.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    @(negedge clk);
    checkVal("drain_pending", SW'(expQ.size() + errQ.size()), '0);
    expQ.delete();
    errQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int base;
    bit done;
    logic first;

    rst      = 1'b1;
    in_data  = '0;
    in_nd    = 1'b0;
    in_first = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("reset_out_nd", SW'(out_nd), '0);
    checkVal("reset_out_data", out_data, '0);
    checkVal("reset_error", SW'(error), '0);
    rst = 1'b0;

    $display("[TB] single frame");
    for (int i = 0; i < N; i++) applyStimulus(SW'(i), 1'b1, i == 0);
    applyStimulus('0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] continuous stream");
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < N; i++) applyStimulus(SW'(16 * (f + 1) + i), 1'b1, i == 0);
    applyStimulus('0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] gapped input");
    for (int i = 0; i < N; i++) begin
      applyStimulus(SW'(200 + i), 1'b1, i == 0);
      applyStimulus('0, 1'b0, 1'b0);
    end
    waitDrain();

    $display("[TB] framing error");
    for (int i = 0; i < 5; i++) applyStimulus(SW'(i), 1'b1, i == 0);
    applyStimulus(SW'(100), 1'b1, 1'b1);
    for (int i = 101; i < 108; i++) applyStimulus(SW'(i), 1'b1, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] randomized frames");
    for (int f = 0; f < 8; f++) begin
      idx  = 0;
      done = 1'b0;
      while (!done) begin
        if ($urandom_range(2) == 0) begin
          applyStimulus('0, 1'b0, 1'b0);
        end else begin
          first = (idx == 0) ? ($urandom_range(1) == 1) : ($urandom_range(11) == 0);
          applyStimulus(SW'($urandom), 1'b1, first);
          idx = (first && idx != 0) ? 1 : idx + 1;
          if (idx == N) done = 1'b1;
        end
      end
    end
    applyStimulus('0, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] reset mid-burst");
    base = outSeen;
    for (int i = 0; i < N; i++) applyStimulus(SW'(300 + i), 1'b1, i == 0);
    applyStimulus('0, 1'b0, 1'b0);
    for (int k = 0; k < 40 && outSeen < base + 4; k++) begin
      @(negedge clk);
      #1;
    end
    checkVal("out_nd_before_rst", SW'(out_nd), SW'(1));
    #1 rst = 1'b1;
    #1;
    checkVal("rst_out_nd", SW'(out_nd), '0);
    checkVal("rst_out_data", out_data, '0);
    checkVal("rst_error", SW'(error), '0);
    expQ.delete();
    errQ.delete();
    frameBuf.delete();
    lastSched = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) applyStimulus(SW'(i), 1'b1, i == 0);
    applyStimulus('0, 1'b0, 1'b0);
    waitDrain();

    checkVal("full_on_write_bank", SW'(invViol), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
